uart_sha_ctrl: RTL and testbench

Sequencer between the UART byte FIFOs and the SHA-256 core. It receives a framed message over the UART RX FIFO: a 2-byte big-endian length header followed by the payload. It packs the payload into 512-bit blocks, applies SHA-256 padding and drives the core block by block. It then streams the 32-byte digest back through the UART TX FIFO.

---
 rtl/uart_sha_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_sha_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sha_ctrl.sv
// Sequencer between the UART byte FIFOs and a SHA-256 core. It takes a length-framed message, pads it into blocks, hashes it and returns the digest.
// Optional inter-byte timeout is enabled by defining UART_SHA_TIMEOUT_EN.
module uart_sha_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000000,
    parameter int unsigned MAX_LEN        = 65535
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         rx_empty,
    input  logic [7:0]   rx_data,
    output logic         rx_rd,
    input  logic         tx_full,
    output logic         tx_wr,
    output logic [7:0]   tx_data,
    output logic         sha_init,
    output logic         sha_next,
    output logic [511:0] sha_block,
    input  logic         sha_ready,
    input  logic [255:0] sha_digest,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {S_IDLE, S_HDR_LO, S_LOAD, S_PAD, S_HASH, S_WAIT, S_SEND} state_t;
    typedef enum logic [1:0] {PH_MARK, PH_ZERO, PH_LEN} pad_t;

    state_t          state;
    pad_t            phase;
    logic [7:0]      len_hi;
    logic [15:0]     len;
    logic [15:0]     remaining;
    logic [5:0]      idx;
    logic [4:0]      cnt;
    logic            first;
    logic            last;
    logic            skip;
    logic [255:0]    digest;
    logic [63:0][7:0] blk;
    logic [7:0][7:0] len_bytes;
    logic [15:0]     hdr_len;
    logic [7:0]      wr_byte;
    logic            wr_en;
    logic            pop;
    logic            push;

    // NOTE: rx_rd/tx_wr are combinational from state and FIFO flags; registering them would pop an empty
    // show-ahead FIFO or push into a full one a cycle after the flag changed.
    assign pop   = !rst_i && (state inside {S_IDLE, S_HDR_LO, S_LOAD}) && !rx_empty;
    assign push  = !rst_i && (state == S_SEND) && !tx_full;
    assign rx_rd = pop;
    assign tx_wr = push;

    // The digest shifts out MSB byte first and is all-zero whenever nothing is being sent.
    assign tx_data   = digest[255:248];
    assign sha_block = blk;
    assign busy      = (state != S_IDLE);
    assign hdr_len   = {len_hi, rx_data};
    assign len_bytes = {45'd0, len, 3'd0};
    assign wr_en     = ((state == S_LOAD) && pop) || (state == S_PAD);

    always_comb begin
        wr_byte = 8'h00;
        if (state == S_LOAD)
            wr_byte = rx_data;
        else if (phase == PH_MARK)
            wr_byte = 8'h80;
        else if (phase == PH_LEN || idx == 6'd56)
            wr_byte = len_bytes[~idx[2:0]];
    end

`ifdef UART_SHA_TIMEOUT_EN
    logic [31:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state     <= S_IDLE;
            phase     <= PH_MARK;
            len_hi    <= 8'h00;
            len       <= 16'h0000;
            remaining <= 16'h0000;
            idx       <= 6'd0;
            cnt       <= 5'd0;
            first     <= 1'b0;
            last      <= 1'b0;
            skip      <= 1'b0;
            digest    <= '0;
            // NOTE: the block buffer is reset only because sha_block must read zero out of reset;
            // a pure data store would normally be left unreset.
            blk       <= '0;
            sha_init  <= 1'b0;
            sha_next  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef UART_SHA_TIMEOUT_EN
            to_cnt    <= 32'd0;
`endif
        end else begin
            sha_init <= 1'b0;
            sha_next <= 1'b0;
            done     <= 1'b0;
            if (wr_en)
                blk[~idx] <= wr_byte;

            case (state)
                S_IDLE: if (pop) begin
                    len_hi <= rx_data;
                    err    <= 1'b0;
                    state  <= S_HDR_LO;
                end
                S_HDR_LO: if (pop) begin
                    len       <= hdr_len;
                    remaining <= hdr_len;
                    idx       <= 6'd0;
                    first     <= 1'b1;
                    last      <= 1'b0;
                    phase     <= PH_MARK;
                    if (32'(hdr_len) > MAX_LEN) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else if (hdr_len == 16'd0)
                        state <= S_PAD;
                    else
                        state <= S_LOAD;
                end
                S_LOAD: if (pop) begin
                    idx       <= idx + 6'd1;
                    remaining <= remaining - 16'd1;
                    // A full block takes priority so a 64-byte boundary yields a separate pad block.
                    if (idx == 6'd63)
                        state <= S_HASH;
                    else if (remaining == 16'd1)
                        state <= S_PAD;
                end
                S_PAD: begin
                    idx <= idx + 6'd1;
                    if (phase == PH_MARK)
                        phase <= PH_ZERO;
                    else if (phase == PH_ZERO && idx == 6'd56)
                        phase <= PH_LEN;
                    if (idx == 6'd63) begin
                        last  <= (phase == PH_LEN);
                        state <= S_HASH;
                    end
                end
                S_HASH: if (sha_ready) begin
                    sha_init <= first;
                    sha_next <= !first;
                    first    <= 1'b0;
                    skip     <= 1'b1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (skip)
                        skip <= 1'b0;
                    else if (sha_ready) begin
                        if (last) begin
                            digest <= sha_digest;
                            cnt    <= 5'd0;
                            state  <= S_SEND;
                        end else
                            state <= (remaining != 16'd0) ? S_LOAD : S_PAD;
                    end
                end
                S_SEND: if (push) begin
                    digest <= {digest[247:0], 8'h00};
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

`ifdef UART_SHA_TIMEOUT_EN
            // Placed after the case so the abort overrides any state update made above.
            if (pop || !(state inside {S_HDR_LO, S_LOAD}))
                to_cnt <= 32'd0;
            else if (rx_empty) begin
                if (to_cnt == TIMEOUT_CYCLES - 1) begin
                    err    <= 1'b1;
                    state  <= S_IDLE;
                    to_cnt <= 32'd0;
                end else
                    to_cnt <= to_cnt + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_sha_ctrl.sv
// Directed bench for uart_sha_ctrl: FIFO and SHA-core stubs, hand-computed blocks and digests.
module tb_uart_sha_ctrl;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         rx_empty = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_rd;
    logic         tx_full = 1'b0;
    logic         tx_wr;
    logic [7:0]   tx_data;
    logic         sha_init;
    logic         sha_next;
    logic [511:0] sha_block;
    logic         sha_ready = 1'b1;
    logic [255:0] sha_digest = '0;
    logic         busy;
    logic         done;
    logic         err;

    uart_sha_ctrl #(.TIMEOUT_CYCLES(50), .MAX_LEN(1000)) dut (
        .clk(clk), .rst_i(rst_i), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data), .sha_init(sha_init),
        .sha_next(sha_next), .sha_block(sha_block), .sha_ready(sha_ready),
        .sha_digest(sha_digest), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_ALT   = {8{32'h5a5a_0001}};

    // Stub-side state: rx_mem is the RX stream, rx_ptr its head; owned per process.
    logic [7:0]   rx_mem[$];
    int           rx_ptr = 0;
    logic [7:0]   tx_got[$];
    logic [511:0] blk_q[$];
    int n_init = 0, n_next = 0, n_done = 0, pops = 0;
    int rx_viol = 0, tx_viol = 0, sha_viol = 0, sha_busy = 0;
    logic rx_hold = 1'b0;
    int   bp_left = 0, bp_last = -1;
    logic rx_toggle = 1'b0;
    int   bp_at = -1;
    logic [255:0] dig_val = '0;
    int total = 0, bad = 0;
    int b_tx, b_blk, b_init, b_next, b_done;

    always @(posedge clk) begin
        if (rx_rd) begin
            if (rx_empty) rx_viol++;
            rx_ptr++;
            pops++;
        end
        if (tx_wr) begin
            tx_got.push_back(tx_data);
            if (tx_full) tx_viol++;
        end
        if (sha_init || sha_next) begin
            blk_q.push_back(sha_block);
            if (!sha_ready || (sha_init && sha_next)) sha_viol++;
            if (sha_init) n_init++; else n_next++;
            sha_busy = 4;
        end else if (sha_busy > 0)
            sha_busy--;
        if (done) n_done++;
    end

    always @(negedge clk) begin
        rx_hold  = rx_toggle ? !rx_hold : 1'b0;
        rx_empty = (rx_ptr >= rx_mem.size()) || rx_hold;
        rx_data  = (rx_ptr < rx_mem.size()) ? rx_mem[rx_ptr] : 8'h00;
        if (tx_got.size() == bp_at && bp_last != bp_at) begin
            bp_last = bp_at;
            bp_left = 10;
        end
        tx_full = (bp_left > 0);
        if (bp_left > 0) bp_left--;
        sha_ready  = (sha_busy == 0);
        sha_digest = sha_ready ? dig_val : ~dig_val;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        rx_mem.push_back(b);
    endtask

    task automatic send_hdr(input int n);
        send(8'(n >> 8));
        send(8'(n));
    endtask

    task automatic wait_pops(input int target, input string tag);
        int t = 0;
        while (pops < target && t < 200) begin step(1); t++; end
        check({tag, " pops"}, pops, target);
    endtask

    task automatic begin_case(input logic [255:0] d);
        dig_val = d;
        b_tx    = tx_got.size();
        b_blk   = blk_q.size();
        b_init  = n_init;
        b_next  = n_next;
        b_done  = n_done;
    endtask

    function automatic logic [511:0] blk(input int k);
        return (b_blk + k < blk_q.size()) ? blk_q[b_blk + k] : {512{1'bx}};
    endfunction

    task automatic end_case(input string tag, input int ei, input int en, input logic [255:0] d);
        logic [255:0] got = '0;
        int t = 0;
        while (n_done == b_done && t < 4000) begin step(1); t++; end
        step(2);
        check({tag, " done"}, n_done - b_done, 1);
        check({tag, " init"}, n_init - b_init, ei);
        check({tag, " next"}, n_next - b_next, en);
        check({tag, " pushes"}, tx_got.size() - b_tx, 32);
        for (int i = 0; i < 32; i++)
            got = {got[247:0], (b_tx + i < tx_got.size()) ? tx_got[b_tx + i] : 8'hxx};
        check({tag, " digest"}, got, d);
        check({tag, " busy"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_rd"}, rx_rd, 0);
        check({tag, " tx_wr"}, tx_wr, 0);
        check({tag, " sha_init"}, sha_init, 0);
        check({tag, " sha_next"}, sha_next, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " sha_block"}, sha_block, 0);
    endtask

    initial begin
        logic [447:0] m56;
        logic [511:0] exp;
        int p0;
        int t;
        m56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

        step(3);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        step(1);

        begin_case(D_ABC);
        send_hdr(3); send(8'h61); send(8'h62); send(8'h63);
        end_case("abc", 1, 0, D_ABC);
        check("abc block", blk(0), {24'h616263, 8'h80, 416'h0, 64'd24});

        // Header above MAX_LEN (1000 here) flags err and returns to IDLE without hashing.
        p0 = n_init + n_next;
        send_hdr(1001);
        wait_pops(pops + 2, "ovl");
        step(2);
        check("ovl err", err, 1);
        check("ovl busy", busy, 0);
        check("ovl sha", n_init + n_next, p0);

        begin_case(D_EMPTY);
        send_hdr(0);
        end_case("empty", 1, 0, D_EMPTY);
        check("empty block", blk(0), {8'h80, 440'h0, 64'd0});
        check("empty err cleared", err, 0);

        begin_case(D_56);
        send_hdr(56);
        for (int i = 0; i < 56; i++) send(m56[447 - 8*i -: 8]);
        end_case("m56", 1, 1, D_56);
        check("m56 block0", blk(0), {m56, 8'h80, 56'h0});
        check("m56 block1", blk(1), {448'h0, 64'd448});

        begin_case(D_ALT);
        send_hdr(55);
        for (int i = 0; i < 55; i++) send(8'(i + 1));
        end_case("m55", 1, 0, D_ALT);
        exp = '0;
        for (int i = 0; i < 55; i++) exp[511 - 8*i -: 8] = 8'(i + 1);
        exp[71:64] = 8'h80;
        exp[63:0]  = 64'd440;
        check("m55 block", blk(0), exp);

        begin_case(~D_ALT);
        send_hdr(64);
        for (int i = 0; i < 64; i++) send(8'(i + 1));
        end_case("m64", 1, 1, ~D_ALT);
        for (int i = 0; i < 64; i++) exp[511 - 8*i -: 8] = 8'(i + 1);
        check("m64 block0", blk(0), exp);
        check("m64 block1", blk(1), {8'h80, 440'h0, 64'd512});

        // Backpressure on TX after the 5th push, RX flag toggling every cycle.
        begin_case(D_ABC);
        rx_toggle = 1'b1;
        bp_at = b_tx + 5;
        send_hdr(3); send(8'h61); send(8'h62); send(8'h63);
        end_case("bp", 1, 0, D_ABC);
        check("bp block", blk(0), {24'h616263, 8'h80, 416'h0, 64'd24});
        check("bp push while full", tx_viol, 0);
        rx_toggle = 1'b0;

`ifdef UART_SHA_TIMEOUT_EN
        begin_case(D_ABC);
        send_hdr(5); send(8'h61); send(8'h62);
        wait_pops(pops + 4, "to");
        step(45);
        check("to early err", err, 0);
        check("to early busy", busy, 1);
        t = 0;
        while (!err && t < 30) begin step(1); t++; end
        check("to err", err, 1);
        check("to busy", busy, 0);
        check("to sha", (n_init - b_init) + (n_next - b_next), 0);
        begin_case(D_ABC);
        send_hdr(3); send(8'h61); send(8'h62); send(8'h63);
        end_case("to abc", 1, 0, D_ABC);
        check("to abc err", err, 0);
`else
        // Without the timeout a starved LOAD simply stalls, then resumes.
        begin_case(D_ALT);
        p0 = pops;
        send_hdr(5); send(8'h61); send(8'h62);
        step(200);
        check("stall busy", busy, 1);
        check("stall err", err, 0);
        check("stall pops", pops - p0, 4);
        check("stall sha", n_init - b_init, 0);
        send(8'h63); send(8'h64); send(8'h65);
        end_case("stall", 1, 0, D_ALT);
        check("stall block", blk(0), {40'h6162636465, 8'h80, 400'h0, 64'd40});
`endif

        // Reset while the 2nd payload byte of a 5-byte frame is at the FIFO head.
        p0 = pops;
        send_hdr(5);
        for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
        wait_pops(p0 + 3, "rst");
        rst_i = 1'b1;
        while (rx_mem.size() > rx_ptr) void'(rx_mem.pop_back());
        step(1);
        check_reset_outputs("rst mid");
        rst_i = 1'b0;
        p0 = n_init + n_next;
        step(5);
        check("rst no sha", n_init + n_next, p0);
        begin_case(D_ABC);
        send_hdr(3); send(8'h61); send(8'h62); send(8'h63);
        end_case("rst abc", 1, 0, D_ABC);
        check("rst abc block", blk(0), {24'h616263, 8'h80, 416'h0, 64'd24});

        check("rx pop while empty", rx_viol, 0);
        check("sha pulse rules", sha_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
